ysyx_23060229_idu_pipe: RTL



---
 rtl/ysyx_23060229_idu_pkg.sv | 84 ++++++++
 rtl/ysyx_23060229_idu_dec.sv | 97 +++++++++
 rtl/ysyx_23060229_idu_pipe.sv | 95 +++++++++
 3 files changed

// File: rtl/ysyx_23060229_idu_pkg.sv
// Shared decode constants: typ codes, opcode/funct3 values, access-size encodings
// and the decoded bundle layout used between the decoder and the pipe register.
package ysyx_23060229_idu_pkg;

  localparam int unsigned IDU_XLEN  = 32;
  localparam int unsigned IDU_TYP_W = 7;
  localparam int unsigned REG_W     = 5;

  localparam logic [IDU_TYP_W-1:0] TYP_NONE   = 7'd0;
  localparam logic [IDU_TYP_W-1:0] TYP_ADDI   = 7'd1;
  localparam logic [IDU_TYP_W-1:0] TYP_ADD    = 7'd2;
  localparam logic [IDU_TYP_W-1:0] TYP_LUI    = 7'd3;
  localparam logic [IDU_TYP_W-1:0] TYP_AUIPC  = 7'd4;
  localparam logic [IDU_TYP_W-1:0] TYP_JAL    = 7'd5;
  localparam logic [IDU_TYP_W-1:0] TYP_JALR   = 7'd6;
  localparam logic [IDU_TYP_W-1:0] TYP_BEQ    = 7'd7;
  localparam logic [IDU_TYP_W-1:0] TYP_BNE    = 7'd8;
  localparam logic [IDU_TYP_W-1:0] TYP_LB     = 7'd9;
  localparam logic [IDU_TYP_W-1:0] TYP_LH     = 7'd10;
  localparam logic [IDU_TYP_W-1:0] TYP_LW     = 7'd11;
  localparam logic [IDU_TYP_W-1:0] TYP_LBU    = 7'd12;
  localparam logic [IDU_TYP_W-1:0] TYP_LHU    = 7'd13;
  localparam logic [IDU_TYP_W-1:0] TYP_SB     = 7'd14;
  localparam logic [IDU_TYP_W-1:0] TYP_SH     = 7'd15;
  localparam logic [IDU_TYP_W-1:0] TYP_SW     = 7'd16;
  localparam logic [IDU_TYP_W-1:0] TYP_EBREAK = 7'd17;
  localparam logic [IDU_TYP_W-1:0] TYP_CSRRW  = 7'd18;
  localparam logic [IDU_TYP_W-1:0] TYP_CSRRS  = 7'd19;
  localparam logic [IDU_TYP_W-1:0] TYP_ECALL  = 7'd20;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;
  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_CSRRS = 3'b010;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_B    = 2'b01;
  localparam logic [1:0] SZ_H    = 2'b10;
  localparam logic [1:0] SZ_W    = 2'b11;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

  typedef struct packed {
    logic [IDU_TYP_W-1:0] typ;
    logic [REG_W-1:0]     rs1;
    logic [REG_W-1:0]     rs2;
    logic [REG_W-1:0]     rd;
    logic [IDU_XLEN-1:0]  imm;
    logic                 reg_wen;
    logic [1:0]           mem_wr;
    logic [1:0]           mem_rd;
    logic                 mem_rd_sext;
    logic                 illegal;
  } dec_bundle_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } idu_state_e;

  // funct3[1:0] of a legal load/store maps 00/01/10 onto sizes 01/10/11
  function automatic logic [1:0] mem_size(input logic [2:0] f3);
    return 2'(f3[1:0] + 2'd1);
  endfunction

endpackage

// File: rtl/ysyx_23060229_idu_dec.sv
// Combinational RV32I-subset decoder with immediate generation.
// YSYX_23060229_IDU_ZICSR_EN adds CSRRW/CSRRS/ECALL; ECALL then requests a halt.
module ysyx_23060229_idu_dec
  import ysyx_23060229_idu_pkg::*;
(
  input  logic [31:0]  inst,
  output dec_bundle_t  dec,
  output logic         halt_req
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        use_rs1, use_rs2, use_rd;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // typ/imm/memory fields per opcode; register fields gated by use flags afterwards
  always_comb begin
    dec      = '0;
    halt_req = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    case (opcode)
      OP_IMM: if (f3 == F3_ADD) begin
        dec.typ = TYP_ADDI; dec.imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OP_REG: if (f3 == F3_ADD && f7 == 7'b0) begin
        dec.typ = TYP_ADD; use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
      end
      OP_LUI:   begin dec.typ = TYP_LUI;   dec.imm = imm_u; use_rd = 1'b1; end
      OP_AUIPC: begin dec.typ = TYP_AUIPC; dec.imm = imm_u; use_rd = 1'b1; end
      OP_JAL:   begin dec.typ = TYP_JAL;   dec.imm = imm_j; use_rd = 1'b1; end
      OP_JALR: if (f3 == 3'b000) begin
        dec.typ = TYP_JALR; dec.imm = imm_i; use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OP_BRANCH: if (f3 == F3_BEQ || f3 == F3_BNE) begin
        dec.typ = (f3 == F3_BEQ) ? TYP_BEQ : TYP_BNE;
        dec.imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_LOAD: if (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU) begin
        case (f3)
          F3_B:    dec.typ = TYP_LB;
          F3_H:    dec.typ = TYP_LH;
          F3_W:    dec.typ = TYP_LW;
          F3_BU:   dec.typ = TYP_LBU;
          default: dec.typ = TYP_LHU;
        endcase
        dec.imm         = imm_i;
        dec.mem_rd      = mem_size(f3);
        dec.mem_rd_sext = ~f3[2];
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OP_STORE: if (f3 == F3_B || f3 == F3_H || f3 == F3_W) begin
        case (f3)
          F3_B:    dec.typ = TYP_SB;
          F3_H:    dec.typ = TYP_SH;
          default: dec.typ = TYP_SW;
        endcase
        dec.imm    = imm_s;
        dec.mem_wr = mem_size(f3);
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_SYSTEM: begin
        if (inst == INST_EBREAK) begin
          dec.typ = TYP_EBREAK; halt_req = 1'b1;
        end
`ifdef YSYX_23060229_IDU_ZICSR_EN
        else if (inst == INST_ECALL) begin
          dec.typ = TYP_ECALL; halt_req = 1'b1;
        end else if (f3 == F3_CSRRW || f3 == F3_CSRRS) begin
          dec.typ = (f3 == F3_CSRRW) ? TYP_CSRRW : TYP_CSRRS;
          dec.imm = {20'b0, inst[31:20]};
          use_rs1 = 1'b1; use_rd = 1'b1;
        end
`endif
      end
      default: ;
    endcase
    dec.rs1     = use_rs1 ? inst[19:15] : '0;
    dec.rs2     = use_rs2 ? inst[24:20] : '0;
    dec.rd      = use_rd  ? inst[11:7]  : '0;
    dec.reg_wen = use_rd && (inst[11:7] != 5'd0);
    dec.illegal = (dec.typ == TYP_NONE);
  end

endmodule

// File: rtl/ysyx_23060229_idu_pipe.sv
// Registered decode stage: valid/ready output register, RUN/HALT FSM and flush.
// Optional CSR/ECALL decode is enabled by YSYX_23060229_IDU_ZICSR_EN.
module ysyx_23060229_idu_pipe
  import ysyx_23060229_idu_pkg::*;
#(
  parameter int unsigned XLEN  = IDU_XLEN,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned TYP_W = IDU_TYP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [TYP_W-1:0] typ,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic             reg_wen,
  output logic [1:0]       mem_wr_quest,
  output logic [1:0]       mem_rd_quest,
  output logic             mem_rd_sext,
  output logic             illegal,
  output logic             halted
);

  dec_bundle_t     dec_bundle;
  logic            dec_halt;
  dec_bundle_t     bundle_q;
  logic [PC_W-1:0] pc_q;
  logic            valid_q, valid_d;
  idu_state_e      state_q, state_d;
  logic            xfer;

  ysyx_23060229_idu_dec u_dec (
    .inst     (inst),
    .dec      (dec_bundle),
    .halt_req (dec_halt)
  );

  assign in_ready = rst_n & ~flush & (state_q == ST_RUN) & (~valid_q | out_ready);
  assign xfer     = in_valid & in_ready;

  // Next-state: flush wins, then a transfer, then a plain consume
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    if (flush) begin
      state_d = ST_RUN;
      valid_d = 1'b0;
    end else if (xfer) begin
      valid_d = 1'b1;
      if (dec_halt) state_d = ST_HALT;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      valid_q  <= 1'b0;
      bundle_q <= '0;
      pc_q     <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (xfer) begin
        bundle_q <= dec_bundle;
        pc_q     <= in_pc;
      end
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign typ          = TYP_W'(bundle_q.typ);
  assign rs1          = bundle_q.rs1;
  assign rs2          = bundle_q.rs2;
  assign rd           = bundle_q.rd;
  assign imm          = XLEN'($signed(bundle_q.imm));
  assign reg_wen      = bundle_q.reg_wen;
  assign mem_wr_quest = bundle_q.mem_wr;
  assign mem_rd_quest = bundle_q.mem_rd;
  assign mem_rd_sext  = bundle_q.mem_rd_sext;
  assign illegal      = bundle_q.illegal;
  assign halted       = (state_q == ST_HALT);

endmodule
